// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: slot, grant and read-tag encodings shared by vram_arbiter and its slot timer
package vram_arb_pkg;
   localparam logic [1:0] SLOT_DISP  = 2'd0;
   localparam logic [1:0] SLOT_CMD_A = 2'd1;
   localparam logic [1:0] SLOT_CMD_B = 2'd2;
   typedef enum logic {GNT_WRITE = 1'b0, GNT_READ = 1'b1} gnt_t;
   typedef enum logic {TAG_DISP = 1'b0, TAG_CMD = 1'b1} tag_t;
   function automatic logic [1:0] next_slot(input logic [1:0] s);
      return s == SLOT_CMD_B ? SLOT_DISP : s + 2'd1;
   endfunction
endpackage

// File: rtl/vram_slot_timer.sv
// vram_slot_timer: three-slot pixel-period counter resynchronised by pix_stb, with sticky cadence error
//   clk, nrst (sync, active-high)  clock and reset
//   pix_stb                        slot-0 marker pulse
//   slot                           slot of the current cycle (0 forced while pix_stb is high)
//   sync_err                       sticky: pix_stb seen out of cadence
module vram_slot_timer
   import vram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       pix_stb,
   output logic [1:0] slot,
   output logic       sync_err
);
   logic [1:0] slot_q;
   // slot_q is the previous cycle's slot, so an in-cadence strobe arrives while it reads SLOT_CMD_B
   assign slot = pix_stb ? SLOT_DISP : next_slot(slot_q);
   always_ff @(posedge clk) begin
      if (nrst) begin
         slot_q   <= SLOT_CMD_B;
         sync_err <= 1'b0;
      end else begin
         slot_q <= slot;
         if (pix_stb && slot_q != SLOT_CMD_B) sync_err <= 1'b1;
      end
   end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: time-slot arbiter sharing one single-port VRAM between display fetch (slot 0) and commands (slots 1-2)
//   clk, nrst (sync, active-high)                     clock and reset
//   pix_stb, disp_req, disp_addr                      display request, sampled in slot 0
//   disp_data, disp_valid                             fetched pixel and its 1-cycle strobe
//   wr_valid, wr_addr, wr_data, wr_ready              command write port
//   rd_valid, rd_addr, rd_ready, rd_data, rd_rvalid   command readback port (VRAM_ARB_RDBACK_EN only)
//   ram_addr, ram_wdata, ram_we, ram_rdata            single-port synchronous RAM
//   sync_err                                          sticky pix_stb cadence error
// Build option: define VRAM_ARB_RDBACK_EN for the readback port and write/read round-robin.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              pix_stb,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
`ifdef VRAM_ARB_RDBACK_EN
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_rvalid,
`endif
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              sync_err
);
   logic [1:0]        slot;
   logic              run, cmd_slot, disp_rd, wr_xfer, rd_xfer, rd_pend;
   logic [ADDR_W-1:0] addr_q, cmd_rd_addr;
   logic [DATA_W-1:0] wdata_q;
   tag_t              tag_in, tag_q;

   vram_slot_timer u_timer (.clk(clk), .nrst(nrst), .pix_stb(pix_stb), .slot(slot), .sync_err(sync_err));

   assign run      = !nrst;
   assign cmd_slot = run && slot != SLOT_DISP;
   assign disp_rd  = run && slot == SLOT_DISP && disp_req;
   assign wr_xfer  = wr_valid && wr_ready;

`ifdef VRAM_ARB_RDBACK_EN
   gnt_t last_grant;
   // each ready looks only at the other port, so a lone requester is never blocked
   assign wr_ready    = cmd_slot && (!rd_valid || last_grant == GNT_READ);
   assign rd_ready    = cmd_slot && (!wr_valid || last_grant == GNT_WRITE);
   assign rd_xfer     = rd_valid && rd_ready;
   assign cmd_rd_addr = rd_addr;
   assign tag_in      = rd_xfer ? TAG_CMD : TAG_DISP;
   always_ff @(posedge clk) begin
      if (nrst) last_grant <= GNT_READ;
      else if (wr_xfer) last_grant <= GNT_WRITE;
      else if (rd_xfer) last_grant <= GNT_READ;
   end
   always_ff @(posedge clk) begin
      if (nrst) begin
         rd_rvalid <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_rvalid <= rd_pend && tag_q == TAG_CMD;
         if (rd_pend && tag_q == TAG_CMD) rd_data <= ram_rdata;
      end
   end
`else
   assign wr_ready    = cmd_slot;
   assign rd_xfer     = 1'b0;
   assign cmd_rd_addr = '0;
   assign tag_in      = TAG_DISP;
`endif

   // idle cycles replay the last address/data so the RAM bus only toggles on real accesses
   assign ram_we    = wr_xfer;
   assign ram_addr  = nrst ? '0 : disp_rd ? disp_addr : wr_xfer ? wr_addr : rd_xfer ? cmd_rd_addr : addr_q;
   assign ram_wdata = nrst ? '0 : wr_xfer ? wr_data : wdata_q;

   always_ff @(posedge clk) begin
      if (nrst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_pend    <= 1'b0;
         tag_q      <= TAG_DISP;
         disp_valid <= 1'b0;
         disp_data  <= '0;
      end else begin
         addr_q     <= ram_addr;
         wdata_q    <= ram_wdata;
         rd_pend    <= disp_rd || rd_xfer;
         tag_q      <= tag_in;
         disp_valid <= rd_pend && tag_q == TAG_DISP;
         if (rd_pend && tag_q == TAG_DISP) disp_data <= ram_rdata;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized self-checking bench for vram_arbiter against a cycle-level slot model
module tb_vram_arbiter;
   localparam int AW = 16;
   localparam int DW = 8;
`ifdef VRAM_ARB_RDBACK_EN
   localparam bit RDB = 1'b1;
`else
   localparam bit RDB = 1'b0;
`endif

   logic clk = 1'b0;
   logic nrst = 1'b1, pix_stb = 1'b0, disp_req = 1'b0, wr_valid = 1'b0, rd_valid = 1'b0;
   logic [AW-1:0] disp_addr = '0, wr_addr = '0, rd_addr = '0, ram_addr;
   logic [DW-1:0] wr_data = '0, disp_data, ram_wdata, ram_rdata;
   logic disp_valid, wr_ready, ram_we, sync_err;
`ifdef VRAM_ARB_RDBACK_EN
   logic rd_ready, rd_rvalid;
   logic [DW-1:0] rd_data;
`endif

   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   logic loaded = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pre(input int a);
      return a == 16 ? 8'hA5 : 8'(a * 37 + 5);
   endfunction

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pre(i);
         loaded <= 1'b1;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
      end
   end

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .nrst(nrst), .pix_stb(pix_stb), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_data(disp_data), .disp_valid(disp_valid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
`ifdef VRAM_ARB_RDBACK_EN
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data), .rd_rvalid(rd_rvalid),
`endif
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .sync_err(sync_err)
   );

   int passed = 0, total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   typedef struct packed {logic v; logic cmd; logic [DW-1:0] d;} ret_t;
   ret_t p1 = '0, p2 = '0;
   int pos_pred = 0, pc = 0, wq = 0, rst_left = 0;
   bit err_m = 1'b0, last_rd = 1'b1;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] last_wd = '0, dd_m = '0, rd_m = '0;

   // One clock of the reference: expectations from the slot rules, then state advance at the edge.
   task automatic cycle(input bit chk);
      int pos;
      bit drd, ewr, erd, wx, rx;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      @(negedge clk);
      pos = pix_stb ? 0 : pos_pred;
      drd = !nrst && pos == 0 && disp_req;
      ewr = !nrst && pos != 0 && (!RDB || !rd_valid || last_rd);
      erd = RDB && !nrst && pos != 0 && (!wr_valid || !last_rd);
      wx  = wr_valid && ewr;
      rx  = rd_valid && erd;
      ea  = nrst ? '0 : drd ? disp_addr : wx ? wr_addr : rx ? rd_addr : last_addr;
      ew  = nrst ? '0 : wx ? wr_data : last_wd;
      if (chk) begin
         check("wr_ready", wr_ready, ewr);
         check("ram_we", ram_we, wx);
         check("ram_addr", ram_addr, ea);
         check("ram_wdata", ram_wdata, ew);
         check("disp_valid", disp_valid, p2.v && !p2.cmd);
         check("disp_data", disp_data, dd_m);
         check("sync_err", sync_err, err_m);
`ifdef VRAM_ARB_RDBACK_EN
         check("rd_ready", rd_ready, erd);
         check("rd_rvalid", rd_rvalid, p2.v && p2.cmd);
         check("rd_data", rd_data, rd_m);
`endif
      end
      if (nrst) begin
         pos_pred = 0; err_m = 1'b0; last_rd = 1'b1;
         p1 = '0; p2 = '0; last_addr = '0; last_wd = '0; dd_m = '0; rd_m = '0;
      end else begin
         if (pix_stb && pos_pred != 0) err_m = 1'b1;
         p2 = p1;
         p1 = {drd || rx, rx, drd ? ref_mem[disp_addr] : ref_mem[rd_addr]};
         if (p2.v && !p2.cmd) dd_m = p2.d;
         if (p2.v && p2.cmd) rd_m = p2.d;
         if (wx) ref_mem[wr_addr] = wr_data;
         if (wx) last_rd = 1'b0;
         else if (rx) last_rd = 1'b1;
         last_addr = ea;
         last_wd = ew;
         pos_pred = (pos + 1) % 3;
      end
   endtask

   task automatic drive_pix(input bit early);
      pix_stb = pc == 0 || early;
      pc = pix_stb ? 1 : (pc + 1) % 3;
   endtask

   function automatic logic [AW-1:0] pick();
      return 16'h0100 + 16'($urandom_range(0, 7));
   endfunction

   task automatic reset_cycle();
      @(posedge clk); #1;
      nrst = 1'b1; pix_stb = 1'b0; pc = 0;
      cycle(1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = pre(i);
      repeat (3) begin
         @(posedge clk); #1;
         nrst = 1'b1;
         cycle(0);
      end
      @(posedge clk); #1;
      nrst = 1'b0; pix_stb = 1'b0; pc = 1;
      cycle(1);
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         drive_pix(1'b0);
         disp_req = 1'b1; disp_addr = 16'h0010;
         wr_valid = wq < 4; wr_addr = 16'(16'h0100 + wq); wr_data = 8'(8'h11 * (wq + 1));
         cycle(1);
         if (wr_valid && wr_ready) wq++;
         if (k == 5) check("wr_4_in_2_periods", wq, 4);
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) check("ram_contents", mem[16'h0100 + i], 8'h11 * (i + 1));
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk); #1;
         if (rst_left > 0) begin
            nrst = 1'b1; pix_stb = 1'b0; pc = 0; rst_left--;
         end else if ($urandom_range(0, 199) == 0) begin
            nrst = 1'b1; pix_stb = 1'b0; pc = 0; rst_left = $urandom_range(0, 1);
         end else begin
            nrst = 1'b0;
            drive_pix($urandom_range(0, 29) == 0);
         end
         disp_req = $urandom_range(0, 3) != 0;
         disp_addr = pick();
         wr_valid = $urandom_range(0, 1) == 1;
         wr_addr = pick();
         wr_data = 8'($urandom);
         rd_valid = RDB && $urandom_range(0, 1) == 1;
         rd_addr = pick();
         cycle(1);
      end
      rd_valid = 1'b0;
      reset_cycle();
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         nrst = 1'b0;
         drive_pix(k == 2);
         disp_req = 1'b1; disp_addr = 16'h0010;
         wr_valid = 1'b1; wr_addr = pick(); wr_data = 8'($urandom);
         cycle(1);
         if (k == 2) check("resync_disp_addr", ram_addr, 16'h0010);
      end
      check("sync_err_sticky", sync_err, 1);
      wr_valid = 1'b0;
      reset_cycle();
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         nrst = k == 1;
         pix_stb = k == 0;
         disp_req = k == 0;
         disp_addr = 16'h0010;
         cycle(1);
      end
      check("rst_mid_read_data", disp_data, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
